// File: rtl/route_control_unit_pkg.sv
// route_control_unit_pkg: shared port indices, status codes and FSM states
package route_control_unit_pkg;
    localparam int TAM_FLIT = 16;
    localparam int NPORT = 5;
    localparam logic [2:0] EAST = 3'd0;
    localparam logic [2:0] WEST = 3'd1;
    localparam logic [2:0] NORTH = 3'd2;
    localparam logic [2:0] SOUTH = 3'd3;
    localparam logic [2:0] LOCAL = 3'd4;
    typedef enum logic [1:0] {
        INVALID_REGION = 2'd0,
        VALID_REGION = 2'd1,
        PORT_ERROR = 2'd2
    } find_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROUTE = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;
endpackage

// File: rtl/route_control_unit_compute.sv
// route_compute: dimension-ordered port selection and mesh range check
module route_compute
    import route_control_unit_pkg::*;
#(
    parameter int FLIT_W = TAM_FLIT,
    parameter int MAX_X = 1,
    parameter int MAX_Y = 1
) (
    input logic [FLIT_W-1:0] dest,
    input logic [FLIT_W-1:0] address,
    input logic mode,
    output logic [NPORT-1:0] port,
    output logic error
);
    localparam int CW = FLIT_W / 2;
    logic [CW-1:0] dx, dy, lx, ly;
    logic [2:0] xi, yi, sel;
    assign dx = dest[FLIT_W-1:CW];
    assign dy = dest[CW-1:0];
    assign lx = address[FLIT_W-1:CW];
    assign ly = address[CW-1:0];
    // resolve each axis independently, then pick by dimension order
    always_comb begin
        xi = dx > lx ? EAST : dx < lx ? WEST : LOCAL;
        yi = dy > ly ? NORTH : dy < ly ? SOUTH : LOCAL;
        sel = mode ? (yi != LOCAL ? yi : xi) : (xi != LOCAL ? xi : yi);
        port = '0;
        port[sel] = 1'b1;
        error = (dx > CW'(MAX_X)) || (dy > CW'(MAX_Y));
    end
endmodule

// File: rtl/route_control_unit.sv
// route_control_unit: header routing FSM granting one output port per connection
module route_control_unit
    import route_control_unit_pkg::*;
#(
    parameter int FLIT_W = TAM_FLIT,
    parameter logic [FLIT_W-1:0] ADDRESS = '0,
    parameter int MAX_X = 1,
    parameter int MAX_Y = 1,
    parameter int MODE = 0
) (
    input logic clock,
    input logic reset,
    input logic req,
    input logic [FLIT_W-1:0] dest,
    input logic [NPORT-1:0] portBusy,
    input logic release_conn,
    output logic ack,
    output logic [NPORT-1:0] outputPort,
    output find_t find
);
    state_t state;
    logic [FLIT_W-1:0] dest_q;
    logic [NPORT-1:0] port;
    logic error, busy;
    route_compute #(
        .FLIT_W(FLIT_W),
        .MAX_X(MAX_X),
        .MAX_Y(MAX_Y)
    ) u_compute (
        .dest(dest_q),
        .address(ADDRESS),
        .mode(MODE != 0),
        .port(port),
        .error(error)
    );
    assign busy = |(port & portBusy);
    // IDLE skips a req already answered by the ack pulse so a held req is not re-served
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            ack <= 1'b0;
            outputPort <= '0;
            find <= INVALID_REGION;
            dest_q <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    find <= INVALID_REGION;
                    if (req && !ack) begin
                        dest_q <= dest;
                        state <= S_ROUTE;
                    end
                end
                S_ROUTE, S_WAIT: begin
                    if (error) begin
                        ack <= 1'b1;
                        find <= PORT_ERROR;
                        state <= S_IDLE;
                    end else if (busy) begin
                        state <= S_WAIT;
                    end else begin
                        ack <= 1'b1;
                        outputPort <= port;
                        find <= VALID_REGION;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (release_conn) begin
                        outputPort <= '0;
                        find <= INVALID_REGION;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/route_control_unit.md
ROUTE_CONTROL_UNIT -- requirements
Module: route_control_unit

Interface
REQ-001 Parameter ADDRESS, default 16'h0000, local router address: X in upper half, Y in lower half.
REQ-002 Parameter FLIT_W, default `TAM_FLIT (16), header flit width; coordinate width CW = FLIT_W/2.
REQ-003 Parameter MAX_X, default 1, highest valid X coordinate in the mesh.
REQ-004 Parameter MAX_Y, default 1, highest valid Y coordinate in the mesh.
REQ-005 Parameter MODE, default 0, dimension order: 0 = XY, 1 = YX.
REQ-006 clock  input  1  single clock; all logic on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req  input  1  header present on dest; held high until ack.
REQ-009 dest  input  FLIT_W  header flit carrying destination X (upper CW bits) and Y (lower CW bits).
REQ-010 portBusy  input  `NPORT  one bit per output port; 1 = port currently owned by another input.
REQ-011 release  input  1  one-cycle pulse: tail flit forwarded, connection ends.
REQ-012 ack  output  1  one-cycle pulse: routing decision for current req completed.
REQ-013 outputPort  output  `NPORT  one-hot granted port, held for the whole connection; all-zero otherwise.
REQ-014 find  output  `ROUTERCONTROL  status: `invalidRegion idle/no decision, `validRegion granted, `portError destination outside mesh.

Function
REQ-015 States: IDLE, ROUTE, WAIT, HOLD.
REQ-016 IDLE: when req=1, register dest and go to ROUTE; dest is not sampled again until the next IDLE.
REQ-017 ROUTE: compute the target port from the registered dest in one cycle, using unsigned CW-bit compares.
REQ-018 XY mode: dx>lx EAST; dx<lx WEST; else dy>ly NORTH; dy<ly SOUTH; else LOCAL.
REQ-019 YX mode: same compares with Y resolved before X.
REQ-020 dx>MAX_X or dy>MAX_Y: pulse ack, find=`portError for that cycle, outputPort=0, return to IDLE.
REQ-021 Target port free (portBusy bit 0): go to HOLD, pulse ack, drive outputPort one-hot, find=`validRegion.
REQ-022 Target port busy: go to WAIT; re-check portBusy every cycle and grant, per REQ-021, in the first cycle it reads 0.
REQ-023 Latency: req sampled at edge N gives ack at N+2 at the earliest; WAIT adds one cycle per busy cycle.
REQ-024 HOLD: outputPort and find are stable; release=1 clears both to 0/`invalidRegion and returns to IDLE on the same edge.
REQ-025 release in any state other than HOLD is ignored.
REQ-026 req=1 on the edge that leaves HOLD is not sampled; it is sampled in IDLE on the following edge.
REQ-027 ack is never high for more than one consecutive cycle, and is never asserted outside ROUTE/WAIT exits.
REQ-028 outputPort is always zero or one-hot; it changes only on grant or release.

Reset
REQ-029 reset=1 at any edge, including mid-WAIT or mid-HOLD, forces IDLE, ack=0, outputPort=0, find=`invalidRegion, and clears the dest register.
REQ-030 No request survives reset; the requester re-presents req after reset deasserts.

Structure
REQ-031 Port indices (`EAST=0, `WEST=1, `NORTH=2, `SOUTH=3, `LOCAL=4), `NPORT, `TAM_FLIT, `METADEFLIT, `ROUTERCONTROL, find codes and state encodings are defined in defines.vh.
REQ-032 Port selection is one combinational sub-module, route_compute, with inputs (dest, local address, MODE) and outputs (one-hot port, range error); the FSM and registers live in route_control_unit.
REQ-033 Size target: 150-300 lines of RTL total.

Verification
REQ-034 ADDRESS=16'h0000, MAX_X=MAX_Y=1, MODE=0, dest=16'h0101, portBusy=0, req at edge 0 -> ack at edge 2, outputPort=EAST, find=`validRegion.
REQ-035 Same setup with MODE=1 -> outputPort=NORTH; with dest=16'h0000 -> outputPort=LOCAL.
REQ-036 dest=16'h0200 (X exceeds MAX_X) -> ack at edge 2, find=`portError, outputPort=0, back in IDLE at edge 3.
REQ-037 portBusy[EAST]=1 for 3 cycles, dest=16'h0100 -> no ack for 3 cycles, then ack with EAST granted at edge 5.
REQ-038 Grant held, then reset pulse mid-HOLD -> outputPort=0, find=`invalidRegion on the next edge; release pulse afterwards has no effect.
REQ-039 release and a new req both high in the same cycle in HOLD -> IDLE at that edge, new req sampled one edge later, ack two edges after that.
